// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX and WB. Holds one instruction,
// waits for the data-SRAM response, extends load data, feeds WB and bypass.
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   ex_to_mem_valid/_bus     instruction from EX (195 bits)
//   mem_allow_in             MEM can accept from EX
//   mem_to_wb_valid/_bus     instruction to WB (188 bits)
//   wb_allow_in              WB can accept
//   data_sram_data_ok/rdata  data-SRAM response and read data
//   wb_flush                 WB exception or ertn taken
//   mem_to_id_bus            {fwd_we, fwd_dest, fwd_data, load_wait}
//   mem_ex                   exception/ertn pending in MEM
module mem_stage #(
   parameter int EX_BUS_W = 195,
   parameter int WB_BUS_W = 188
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                ex_to_mem_valid,
   input  logic [EX_BUS_W-1:0] ex_to_mem_bus,
   output logic                mem_allow_in,
   output logic                mem_to_wb_valid,
   output logic [WB_BUS_W-1:0] mem_to_wb_bus,
   input  logic                wb_allow_in,
   input  logic                data_sram_data_ok,
   input  logic [31:0]         data_sram_rdata,
   input  logic                wb_flush,
   output logic [38:0]         mem_to_id_bus,
   output logic                mem_ex
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HOLD  = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_discard;
   logic                w_discard_nxt;
   // mem_req (bit 0) is only needed at acceptance
   logic [EX_BUS_W-1:1] r_bus;
   logic [31:0]         r_ld_hold;

   logic        w_valid;
   logic        w_req_wait;
   logic        w_ok_own;
   logic        w_ready_go;
   logic        w_accept;
   logic        w_leave;
   logic        w_in_req;

   logic        w_ertn;
   logic [5:0]  w_ex_type;
   logic [31:0] w_alu;
   logic        w_gr_we;
   logic [4:0]  w_dest;
   logic        w_res_mem;
   logic [4:0]  w_ld_op;

   logic [31:0] w_word;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ld_data;
   logic [31:0] w_final;
   logic        w_fwd_we;
   logic        w_load_wait;

   assign w_ertn    = r_bus[115];
   assign w_ex_type = r_bus[114:109];
   assign w_alu     = r_bus[108:77];
   assign w_gr_we   = r_bus[76];
   assign w_dest    = r_bus[75:71];
   assign w_res_mem = r_bus[6];
   assign w_ld_op   = r_bus[5:1];

   // Only a clean memory instruction has a response in flight
   assign w_in_req = ex_to_mem_bus[0] & ~|ex_to_mem_bus[114:109];

   assign w_valid    = (r_state == S_HOLD) | (r_state == S_WAIT);
   assign w_req_wait = (r_state == S_WAIT);
   // A response owed to a flushed load is swallowed first
   assign w_ok_own   = data_sram_data_ok & ~r_discard;
   assign w_ready_go = ~w_req_wait | w_ok_own;

   assign mem_allow_in = ~w_valid | (w_ready_go & wb_allow_in);
   assign w_accept     = ex_to_mem_valid & mem_allow_in;
   assign w_leave      = w_valid & w_ready_go & wb_allow_in;

   always_comb begin
      w_discard_nxt = (r_discard & ~data_sram_data_ok)
                    | (wb_flush & w_req_wait & ~w_ok_own);
      w_state_nxt   = r_state;
      if (wb_flush) begin
         w_state_nxt = w_discard_nxt ? S_DRAIN : S_IDLE;
      end else if (w_accept) begin
         w_state_nxt = w_in_req ? S_WAIT : S_HOLD;
      end else if (w_leave) begin
         w_state_nxt = w_discard_nxt ? S_DRAIN : S_IDLE;
      end else if (w_req_wait & w_ok_own) begin
         w_state_nxt = S_HOLD;
      end else if (!w_valid) begin
         w_state_nxt = w_discard_nxt ? S_DRAIN : S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_discard <= 1'b0;
         r_bus     <= '0;
         r_ld_hold <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_discard <= w_discard_nxt;
         if (w_accept) begin
            r_bus <= ex_to_mem_bus[EX_BUS_W-1:1];
         end
         if (w_req_wait & w_ok_own) begin
            r_ld_hold <= data_sram_rdata;
         end
      end
   end

   // Live SRAM data while waiting, held copy once the response is in
   assign w_word = w_req_wait ? data_sram_rdata : r_ld_hold;
   assign w_half = w_alu[1] ? w_word[31:16] : w_word[15:0];

   always_comb begin
      w_byte = w_word[7:0];
      unique case (w_alu[1:0])
         2'd0: w_byte = w_word[7:0];
         2'd1: w_byte = w_word[15:8];
         2'd2: w_byte = w_word[23:16];
         2'd3: w_byte = w_word[31:24];
      endcase
   end

   always_comb begin
      w_ld_data = w_word;
      unique case (1'b1)
         w_ld_op[0]: w_ld_data = {{24{w_byte[7]}}, w_byte};
         w_ld_op[1]: w_ld_data = {24'd0, w_byte};
         w_ld_op[2]: w_ld_data = {{16{w_half[15]}}, w_half};
         w_ld_op[3]: w_ld_data = {16'd0, w_half};
         default:    w_ld_data = w_word;
      endcase
   end

   // Faulting instructions keep the address for badvaddr
   assign w_final = (w_res_mem & ~|w_ex_type) ? w_ld_data : w_alu;

   assign mem_to_wb_valid = w_valid & w_ready_go & ~wb_flush;
   assign mem_to_wb_bus   = {r_bus[194:109], w_final, r_bus[76:7]};

   assign w_fwd_we      = w_valid & w_gr_we & (w_dest != 5'd0);
   assign w_load_wait   = w_valid & w_res_mem & ~w_ready_go;
   assign mem_to_id_bus = {w_fwd_we, w_dest, w_final, w_load_wait};

   assign mem_ex = w_valid & (|w_ex_type | w_ertn);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// Random and directed scenarios against a field-level reference model.
module tb_mem_stage;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         ex_valid = 1'b0;
   logic [194:0] ex_bus = '0;
   logic         allow_in;
   logic         wb_valid;
   logic [187:0] wb_bus;
   logic         wb_allow = 1'b1;
   logic         data_ok = 1'b0;
   logic [31:0]  rdata = '0;
   logic         flush = 1'b0;
   logic [38:0]  id_bus;
   logic         mem_ex;

   int checks = 0;
   int failures = 0;

   mem_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .ex_to_mem_valid   (ex_valid),
      .ex_to_mem_bus     (ex_bus),
      .mem_allow_in      (allow_in),
      .mem_to_wb_valid   (wb_valid),
      .mem_to_wb_bus     (wb_bus),
      .wb_allow_in       (wb_allow),
      .data_sram_data_ok (data_ok),
      .data_sram_rdata   (rdata),
      .wb_flush          (flush),
      .mem_to_id_bus     (id_bus),
      .mem_ex            (mem_ex)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        csr_we;
      logic [13:0] csr_num;
      logic [31:0] wmask;
      logic [31:0] wvalue;
      logic        ertn;
      logic [5:0]  ex_type;
      logic [31:0] alu;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        res_mem;
      logic [4:0]  ld_op;
      logic        mem_req;
   } ins_t;

   function automatic logic [194:0] pack_ex(ins_t i);
      return {i.csr_we, i.csr_num, i.wmask, i.wvalue, i.ertn,
              i.ex_type, i.alu, i.gr_we, i.dest, i.pc, i.inst,
              i.res_mem, i.ld_op, i.mem_req};
   endfunction

   function automatic logic [187:0] pack_wb(ins_t i, logic [31:0] fin);
      return {i.csr_we, i.csr_num, i.wmask, i.wvalue, i.ertn,
              i.ex_type, fin, i.gr_we, i.dest, i.pc, i.inst};
   endfunction

   function automatic ins_t rand_ins();
      ins_t i;
      i.csr_we  = 1'($urandom);
      i.csr_num = 14'($urandom);
      i.wmask   = $urandom;
      i.wvalue  = $urandom;
      i.ertn    = 1'b0;
      i.ex_type = '0;
      i.alu     = $urandom;
      i.gr_we   = 1'($urandom);
      i.dest    = 5'($urandom);
      i.pc      = $urandom;
      i.inst    = $urandom;
      i.res_mem = 1'b0;
      i.ld_op   = '0;
      i.mem_req = 1'b0;
      return i;
   endfunction

   // op: 0=b 1=bu 2=h 3=hu 4=w
   function automatic ins_t mk_load(int op, logic [31:0] addr);
      ins_t i;
      i = rand_ins();
      i.alu     = addr;
      i.gr_we   = 1'b1;
      i.res_mem = 1'b1;
      i.ld_op   = 5'(1 << op);
      i.mem_req = 1'b1;
      return i;
   endfunction

   function automatic logic [31:0] exp_load(int op, logic [31:0] addr,
                                            logic [31:0] rd);
      int unsigned bsh;
      int unsigned hsh;
      logic [31:0] sh;
      int v;
      bsh = 8 * (addr % 4);
      hsh = 16 * ((addr / 2) % 2);
      case (op)
         0: begin sh = rd >> bsh; v = $signed(sh[7:0]); end
         1: begin sh = rd >> bsh; v = int'(sh[7:0]); end
         2: begin sh = rd >> hsh; v = $signed(sh[15:0]); end
         3: begin sh = rd >> hsh; v = int'(sh[15:0]); end
         default: v = rd;
      endcase
      return 32'(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick();
      tick();
      #1;
      checks++;
      if (wb_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_wbv got %b want 0", wb_valid);
      end
      checks++;
      if (allow_in !== 1'b1) begin
         failures++;
         $display("FAIL reset_allow got %b want 1", allow_in);
      end
      checks++;
      if (id_bus !== '0) begin
         failures++;
         $display("FAIL reset_id got %h want 0", id_bus);
      end
      checks++;
      if (wb_bus !== '0 || mem_ex !== 1'b0) begin
         failures++;
         $display("FAIL reset_bus got %h/%b want 0", wb_bus, mem_ex);
      end
      resetn = 1'b1;
   endtask

   task automatic test_loads();
      int          dop[3]  = '{0, 3, 2};
      logic [31:0] dadr[3] = '{32'h1003, 32'h1002, 32'h1000};
      logic [31:0] drd[3]  = '{32'h80FF_1234, 32'h8001_0000,
                               32'h0000_F00F};
      logic [31:0] dexp[3] = '{32'hFFFF_FF80, 32'h0000_8001,
                               32'hFFFF_F00F};
      int          ddly[3] = '{2, 1, 0};
      for (int n = 0; n < 15; n++) begin
         int          op;
         int          dly;
         int          lw;
         logic        bad;
         logic [31:0] adr;
         logic [31:0] rd;
         logic [31:0] ex;
         ins_t        i;
         if (n < 3) begin
            op = dop[n]; adr = dadr[n]; rd = drd[n];
            dly = ddly[n]; ex = dexp[n];
         end else begin
            op  = int'($urandom_range(0, 4));
            adr = $urandom;
            if (op == 2 || op == 3) adr[0] = 1'b0;
            if (op == 4) adr[1:0] = 2'b00;
            rd  = $urandom;
            dly = int'($urandom_range(0, 3));
            ex  = exp_load(op, adr, rd);
         end
         i = mk_load(op, adr);
         tick();
         ex_valid = 1'b1; ex_bus = pack_ex(i);
         data_ok = 1'b0; wb_allow = 1'b1;
         #1;
         checks++;
         if (allow_in !== 1'b1) begin
            failures++;
            $display("FAIL ld_accept%0d got %b want 1", n, allow_in);
         end
         tick();
         ex_valid = 1'b0;
         lw = 0; bad = 1'b0;
         for (int k = 0; k < dly; k++) begin
            #1;
            if (id_bus[0] === 1'b1) lw++;
            if (wb_valid !== 1'b0) bad = 1'b1;
            tick();
         end
         data_ok = 1'b1; rdata = rd;
         #1;
         checks++;
         if (lw != dly || bad) begin
            failures++;
            $display("FAIL ld_wait%0d lw=%0d early=%b want %0d/0",
                     n, lw, bad, dly);
         end
         checks++;
         if (wb_valid !== 1'b1 || wb_bus !== pack_wb(i, ex)) begin
            failures++;
            $display("FAIL ld_data%0d got %b/%h want 1/%h",
                     n, wb_valid, wb_bus[101:70], ex);
         end
         checks++;
         if (id_bus !== {i.dest != 0, i.dest, ex, 1'b0}) begin
            failures++;
            $display("FAIL ld_fwd%0d got %h want %h", n, id_bus,
                     {i.dest != 0, i.dest, ex, 1'b0});
         end
         tick();
         data_ok = 1'b0; rdata = $urandom;
         #1;
         checks++;
         if (wb_valid !== 1'b0 || allow_in !== 1'b1) begin
            failures++;
            $display("FAIL ld_done%0d got %b/%b want 0/1",
                     n, wb_valid, allow_in);
         end
      end
   endtask

   task automatic test_stall();
      ins_t        i;
      logic [31:0] rd;
      int          xf;
      rd = $urandom;
      i  = mk_load(4, {$urandom_range(0, 1023), 2'b00});
      xf = 0;
      tick();
      ex_valid = 1'b1; ex_bus = pack_ex(i); wb_allow = 1'b1;
      tick();
      ex_valid = 1'b0; wb_allow = 1'b0;
      data_ok = 1'b1; rdata = rd;
      #1;
      checks++;
      if (allow_in !== 1'b0 || wb_valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_ok got %b/%b want 0/1", allow_in, wb_valid);
      end
      tick();
      data_ok = 1'b0; rdata = ~rd;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (allow_in !== 1'b0 || wb_bus !== pack_wb(i, rd)) begin
            failures++;
            $display("FAIL stall_hold%0d got %b/%h want 0/%h",
                     k, allow_in, wb_bus[101:70], rd);
         end
         tick();
      end
      wb_allow = 1'b1;
      #1;
      checks++;
      if (wb_bus !== pack_wb(i, rd)) begin
         failures++;
         $display("FAIL stall_out got %h want %h", wb_bus[101:70], rd);
      end
      if (wb_valid === 1'b1) xf++;
      tick();
      #1;
      if (wb_valid === 1'b1) xf++;
      checks++;
      if (xf != 1 || allow_in !== 1'b1) begin
         failures++;
         $display("FAIL stall_xfer got %0d/%b want 1/1", xf, allow_in);
      end
   endtask

   task automatic test_flush_drain();
      ins_t        a;
      ins_t        b;
      logic [31:0] rb;
      logic [31:0] eb;
      logic        pulse;
      a  = mk_load(4, 32'h2000);
      b  = mk_load(1, 32'h3001);
      rb = 32'h1234_AB78;
      eb = 32'h0000_00AB;
      pulse = 1'b0;
      tick();
      ex_valid = 1'b1; ex_bus = pack_ex(a); wb_allow = 1'b1;
      tick();
      ex_valid = 1'b0; flush = 1'b1;
      #1;
      pulse |= wb_valid;
      tick();
      flush = 1'b0; ex_valid = 1'b1; ex_bus = pack_ex(b);
      #1;
      pulse |= wb_valid;
      checks++;
      if (allow_in !== 1'b1) begin
         failures++;
         $display("FAIL drain_accept got %b want 1", allow_in);
      end
      tick();
      ex_valid = 1'b0; data_ok = 1'b1; rdata = 32'hDEAD_0000;
      #1;
      pulse |= wb_valid;
      checks++;
      if (pulse !== 1'b0 || id_bus[0] !== 1'b1) begin
         failures++;
         $display("FAIL drain_discard got %b/%b want 0/1",
                  pulse, id_bus[0]);
      end
      tick();
      data_ok = 1'b0;
      #1;
      checks++;
      if (wb_valid !== 1'b0 || id_bus[0] !== 1'b1) begin
         failures++;
         $display("FAIL drain_wait got %b/%b want 0/1",
                  wb_valid, id_bus[0]);
      end
      tick();
      data_ok = 1'b1; rdata = rb;
      #1;
      checks++;
      if (wb_valid !== 1'b1 || wb_bus !== pack_wb(b, eb)) begin
         failures++;
         $display("FAIL drain_second got %b/%h want 1/%h",
                  wb_valid, wb_bus[101:70], eb);
      end
      tick();
      data_ok = 1'b0;
      #1;
      checks++;
      if (wb_valid !== 1'b0 || allow_in !== 1'b1) begin
         failures++;
         $display("FAIL drain_idle got %b/%b want 0/1", wb_valid, allow_in);
      end
   endtask

   task automatic test_ale();
      ins_t i;
      i = mk_load(2, 32'h1001);
      i.ex_type = 6'b000100;
      tick();
      ex_valid = 1'b1; ex_bus = pack_ex(i); wb_allow = 1'b1;
      tick();
      ex_valid = 1'b0; wb_allow = 1'b0;
      #1;
      checks++;
      if (mem_ex !== 1'b1 || id_bus[0] !== 1'b0) begin
         failures++;
         $display("FAIL ale_ex got %b/%b want 1/0", mem_ex, id_bus[0]);
      end
      checks++;
      if (wb_valid !== 1'b1 || wb_bus !== pack_wb(i, 32'h1001)) begin
         failures++;
         $display("FAIL ale_bus got %b/%h want 1/00001001",
                  wb_valid, wb_bus[101:70]);
      end
      tick();
      flush = 1'b1;
      #1;
      checks++;
      if (wb_valid !== 1'b0) begin
         failures++;
         $display("FAIL ale_flush got %b want 0", wb_valid);
      end
      tick();
      flush = 1'b0; wb_allow = 1'b1;
      #1;
      checks++;
      if (allow_in !== 1'b1 || mem_ex !== 1'b0) begin
         failures++;
         $display("FAIL ale_idle got %b/%b want 1/0", allow_in, mem_ex);
      end
   endtask

   task automatic test_reset_wait();
      ins_t i;
      i = mk_load(0, 32'h40);
      tick();
      ex_valid = 1'b1; ex_bus = pack_ex(i); wb_allow = 1'b1;
      tick();
      ex_valid = 1'b0;
      #1;
      checks++;
      if (id_bus[0] !== 1'b1) begin
         failures++;
         $display("FAIL rstw_wait got %b want 1", id_bus[0]);
      end
      resetn = 1'b0;
      tick();
      #1;
      checks++;
      if (wb_valid !== 1'b0 || allow_in !== 1'b1 || id_bus !== '0) begin
         failures++;
         $display("FAIL rstw_clear got %b/%b/%h want 0/1/0",
                  wb_valid, allow_in, id_bus);
      end
      resetn = 1'b1;
   endtask

   task automatic test_back_to_back();
      ins_t cur;
      ins_t nw;
      logic have;
      logic ev;
      logic wa;
      logic fwd;
      have = 1'b0;
      cur  = rand_ins();
      tick();
      for (int c = 0; c < 60; c++) begin
         nw = rand_ins();
         if ($urandom_range(0, 3) == 0) nw.ex_type = 6'($urandom);
         nw.ertn = ($urandom_range(0, 7) == 0);
         ev = ($urandom_range(0, 3) != 0);
         wa = ($urandom_range(0, 2) != 0);
         ex_valid = ev; ex_bus = pack_ex(nw); wb_allow = wa;
         #1;
         checks++;
         if (wb_valid !== have || allow_in !== (!have || wa)) begin
            failures++;
            $display("FAIL b2b_hs%0d got %b/%b want %b/%b",
                     c, wb_valid, allow_in, have, !have || wa);
         end
         if (have) begin
            fwd = cur.gr_we && (cur.dest != 0);
            checks++;
            if (wb_bus !== pack_wb(cur, cur.alu)) begin
               failures++;
               $display("FAIL b2b_bus%0d got %h want %h",
                        c, wb_bus, pack_wb(cur, cur.alu));
            end
            checks++;
            if (id_bus !== {fwd, cur.dest, cur.alu, 1'b0} ||
                mem_ex !== (cur.ex_type != 0 || cur.ertn)) begin
               failures++;
               $display("FAIL b2b_fwd%0d got %h/%b", c, id_bus, mem_ex);
            end
         end
         if (ev && (!have || wa)) begin
            cur  = nw;
            have = 1'b1;
         end else if (have && wa) begin
            have = 1'b0;
         end
         tick();
      end
      ex_valid = 1'b0;
      wb_allow = 1'b1;
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stall();
      test_flush_drain();
      test_ale();
      test_reset_wait();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
